// File: rtl/sdpram_init_bwe_if.sv
// Port bundle for sdpram_init_bwe: write port, read port and clear handshake.
// The master side drives requests and the slave side (the RAM) returns data.
interface sdpram_init_bwe_if #(
  parameter int RAM_WIDTH  = 32,
  parameter int RAM_DEPTH  = 128,
  parameter int BYTE_WIDTH = 8
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int NB = RAM_WIDTH / BYTE_WIDTH;

  logic                 init_req;
  logic [RAM_WIDTH-1:0] dina;
  logic [AW-1:0]        addra;
  logic [NB-1:0]        wea;
  logic                 enb;
  logic [AW-1:0]        addrb;
  logic [RAM_WIDTH-1:0] doutb;
  logic                 doutb_valid;
  logic                 initial_done;

  modport master (
    output init_req, dina, addra, wea, enb, addrb,
    input  doutb, doutb_valid, initial_done
  );

  modport slave (
    input  init_req, dina, addra, wea, enb, addrb,
    output doutb, doutb_valid, initial_done
  );
endinterface

// File: rtl/sdpram_init_bwe.sv
// Simple dual-port RAM with byte-lane write enables, 1- or 2-cycle read
// latency with a valid strobe, and a hardware clear-to-constant sequence that
// runs after reset (optionally) and again whenever init_req is pulsed.
module sdpram_init_bwe #(
  parameter int                  RAM_WIDTH     = 32,
  parameter int                  RAM_DEPTH     = 128,
  parameter int                  BYTE_WIDTH    = 8,
  parameter int                  READ_LATENCY  = 1,
  parameter logic [RAM_WIDTH-1:0] INIT_VALUE   = '0,
  parameter bit                  INIT_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  sdpram_init_bwe_if.slave   bus
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int NB = RAM_WIDTH / BYTE_WIDTH;

  // Extra bit so a non-power-of-two depth can be range-checked without wrap.
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(RAM_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

  generate
    if (RAM_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("RAM_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
    end
  endgenerate

  typedef enum logic {ST_INIT, ST_READY} state_t;
  localparam state_t RST_STATE = INIT_ON_RESET ? ST_INIT : ST_READY;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  state_t               state_q, state_d;
  logic [AW-1:0]        clr_addr_q, clr_addr_d;
  logic                 done_q;

  logic [NB-1:0]        wr_lanes;
  logic [AW-1:0]        wr_addr;
  logic [RAM_WIDTH-1:0] wr_data;

  logic                 rd_accept;
  logic                 rd_in_range;
  logic [RAM_WIDTH-1:0] rd_data_p0;
  logic                 vld_p0;

  // State register, clear counter and registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      clr_addr_q <= '0;
      done_q     <= ~INIT_ON_RESET;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      done_q     <= (state_d == ST_READY);
    end
  end

  // Next state: walk the clear counter to the last word, or restart on request.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_INIT: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_READY;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      ST_READY: begin
        if (bus.init_req) begin
          state_d    = ST_INIT;
          clr_addr_d = '0;
        end
      end
    endcase
  end

  // Write port mux: the clear sequence owns the port while initialising,
  // otherwise user lanes pass through when the address is in range.
  always_comb begin
    wr_lanes = '0;
    wr_addr  = bus.addra;
    wr_data  = bus.dina;
    if (state_q == ST_INIT) begin
      wr_lanes = '1;
      wr_addr  = clr_addr_q;
      wr_data  = INIT_VALUE;
    end else if ({1'b0, bus.addra} < DEPTH_W) begin
      wr_lanes = bus.wea;
    end
  end

  // Memory array write, one lane at a time; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_lanes[i]) begin
        mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rd_accept   = (state_q == ST_READY) && bus.enb;
  assign rd_in_range = ({1'b0, bus.addrb} < DEPTH_W);

  // Stage p0: array read (read-first against a same-edge write); holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p0 <= '0;
      vld_p0     <= 1'b0;
    end else begin
      vld_p0 <= rd_accept;
      if (rd_accept) begin
        rd_data_p0 <= rd_in_range ? mem[bus.addrb] : '0;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [RAM_WIDTH-1:0] rd_data_p1;
      logic                 vld_p1;

      // Stage p1: output register; only advances when p0 holds a fresh result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) begin
            rd_data_p1 <= rd_data_p0;
          end
        end
      end

      assign bus.doutb       = rd_data_p1;
      assign bus.doutb_valid = vld_p1;
    end else begin : g_lat1
      assign bus.doutb       = rd_data_p0;
      assign bus.doutb_valid = vld_p0;
    end
  endgenerate

  assign bus.initial_done = done_q;

endmodule

// File: tb/tb_sdpram_init_bwe.sv
// Directed bench for sdpram_init_bwe: three instances cover latency 1 with a
// non-zero init word, latency 2, and a non-power-of-two depth.
module tb_sdpram_init_bwe;
  logic clk;
  logic rst_n;
  logic rst_n2;

  int n_cmp;
  int n_err;

  sdpram_init_bwe_if #(.RAM_WIDTH(32), .RAM_DEPTH(128), .BYTE_WIDTH(8)) if0 ();
  sdpram_init_bwe_if #(.RAM_WIDTH(32), .RAM_DEPTH(128), .BYTE_WIDTH(8)) if1 ();
  sdpram_init_bwe_if #(.RAM_WIDTH(32), .RAM_DEPTH(100), .BYTE_WIDTH(8)) if2 ();

  sdpram_init_bwe #(
    .RAM_WIDTH(32), .RAM_DEPTH(128), .BYTE_WIDTH(8), .READ_LATENCY(1),
    .INIT_VALUE(32'hA5A5_A5A5), .INIT_ON_RESET(1'b1)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  sdpram_init_bwe #(
    .RAM_WIDTH(32), .RAM_DEPTH(128), .BYTE_WIDTH(8), .READ_LATENCY(2),
    .INIT_VALUE(32'h0000_0000), .INIT_ON_RESET(1'b1)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  sdpram_init_bwe #(
    .RAM_WIDTH(32), .RAM_DEPTH(100), .BYTE_WIDTH(8), .READ_LATENCY(1),
    .INIT_VALUE(32'h5A5A_0F0F), .INIT_ON_RESET(1'b1)
  ) u2 (.clk(clk), .rst_n(rst_n2), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int done0, done2, low, cnt;
    logic saw_v;
    logic exp_v;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    rst_n2 = 1'b0;
    if0.init_req = 1'b0; if0.dina = '0; if0.addra = '0; if0.wea = '0; if0.enb = 1'b0; if0.addrb = '0;
    if1.init_req = 1'b0; if1.dina = '0; if1.addra = '0; if1.wea = '0; if1.enb = 1'b0; if1.addrb = '0;
    if2.init_req = 1'b0; if2.dina = '0; if2.addra = '0; if2.wea = '0; if2.enb = 1'b0; if2.addrb = '0;

    repeat (3) tick;
    chk("rst_doutb", if0.doutb, 32'h0);
    chk("rst_valid", 32'(if0.doutb_valid), 32'h0);
    chk("rst_done", 32'(if0.initial_done), 32'h0);
    chk("rst_done_d100", 32'(if2.initial_done), 32'h0);
    chk("rst_valid_lat2", 32'(if1.doutb_valid), 32'h0);

    // Power-on clear with user writes and reads hammering u0 throughout.
    rst_n = 1'b1;
    rst_n2 = 1'b1;
    done0 = 0;
    done2 = 0;
    saw_v = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if0.enb = 1'b1;
      if0.addrb = 7'(k - 1);
      if0.addra = 7'(k - 1);
      if0.wea = 4'hF;
      if0.dina = 32'hFFFF_0000 ^ 32'(k);
      tick;
      saw_v = saw_v | if0.doutb_valid;
      if (if2.initial_done && done2 == 0) done2 = k;
      if (if0.initial_done) begin
        done0 = k;
        break;
      end
    end
    if0.enb = 1'b0;
    if0.wea = 4'h0;
    chk("por_done_cycle", 32'(done0), 32'd128);
    chk("por_no_valid", 32'(saw_v), 32'h0);
    chk("por_done_cycle_d100", 32'(done2), 32'd100);

    for (int j = 0; j < 128; j++) begin
      if0.enb = 1'b1;
      if0.addrb = 7'(j);
      tick;
      chk($sformatf("por_rd_%0d", j), if0.doutb, 32'hA5A5_A5A5);
      chk($sformatf("por_rd_v_%0d", j), 32'(if0.doutb_valid), 32'h1);
    end
    if0.enb = 1'b0;
    tick;
    chk("idle_valid_low", 32'(if0.doutb_valid), 32'h0);
    chk("idle_doutb_hold", if0.doutb, 32'hA5A5_A5A5);

    // Byte lanes 0 and 2 only.
    if0.addra = 7'd5; if0.dina = 32'h1122_3344; if0.wea = 4'b0101;
    tick;
    if0.wea = 4'h0;
    if0.enb = 1'b1; if0.addrb = 7'd5;
    tick;
    chk("bwe_rd5", if0.doutb, 32'hA522_A544);
    if0.enb = 1'b0;

    // Read-first collision on address 7.
    if0.addra = 7'd7; if0.dina = 32'h0000_0001; if0.wea = 4'hF;
    tick;
    if0.dina = 32'h0000_0002; if0.enb = 1'b1; if0.addrb = 7'd7;
    tick;
    chk("coll_old", if0.doutb, 32'h0000_0001);
    if0.wea = 4'h0;
    tick;
    chk("coll_new", if0.doutb, 32'h0000_0002);

    // Re-init with an in-flight read and a user write at the request edge.
    if0.init_req = 1'b1; if0.enb = 1'b1; if0.addrb = 7'd5;
    if0.wea = 4'hF; if0.addra = 7'd9; if0.dina = 32'hDEAD_BEEF;
    tick;
    chk("reinit_done_fall", 32'(if0.initial_done), 32'h0);
    chk("reinit_inflight_v", 32'(if0.doutb_valid), 32'h1);
    chk("reinit_inflight_d", if0.doutb, 32'hA522_A544);
    if0.init_req = 1'b0;
    if0.wea = 4'h0;
    low = 1;
    saw_v = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if0.init_req = (c == 50);
      tick;
      saw_v = saw_v | if0.doutb_valid;
      if (if0.initial_done) break;
      low++;
    end
    if0.init_req = 1'b0;
    chk("reinit_low_cycles", 32'(low), 32'd128);
    chk("reinit_no_valid", 32'(saw_v), 32'h0);
    for (int j = 0; j < 128; j++) begin
      if0.enb = 1'b1;
      if0.addrb = 7'(j);
      tick;
      chk($sformatf("reinit_rd_%0d", j), if0.doutb, 32'hA5A5_A5A5);
    end
    if0.enb = 1'b0;

    // Latency 2: fill addr+1, then 10 back-to-back reads.
    for (int a = 0; a < 128; a++) begin
      if1.wea = 4'hF;
      if1.addra = 7'(a);
      if1.dina = 32'(a + 1);
      tick;
    end
    if1.wea = 4'h0;
    for (int c = 1; c <= 13; c++) begin
      if1.enb = (c <= 10);
      if1.addrb = 7'(c - 1);
      tick;
      exp_v = (c >= 2 && c <= 11);
      chk($sformatf("lat2_v_%0d", c), 32'(if1.doutb_valid), 32'(exp_v));
      if (exp_v) chk($sformatf("lat2_d_%0d", c), if1.doutb, 32'(c - 1));
    end
    if1.enb = 1'b0;
    chk("lat2_hold", if1.doutb, 32'd10);

    // Depth 100: reset in the middle of a requested clear.
    if2.enb = 1'b1; if2.addrb = 7'd3; if2.init_req = 1'b1;
    tick;
    chk("d100_inflight_v", 32'(if2.doutb_valid), 32'h1);
    chk("d100_inflight_d", if2.doutb, 32'h5A5A_0F0F);
    if2.enb = 1'b0; if2.init_req = 1'b0;
    repeat (40) tick;
    chk("d100_midclear_hold", if2.doutb, 32'h5A5A_0F0F);
    chk("d100_midclear_done", 32'(if2.initial_done), 32'h0);
    rst_n2 = 1'b0;
    #1;
    chk("d100_rst_doutb", if2.doutb, 32'h0);
    chk("d100_rst_valid", 32'(if2.doutb_valid), 32'h0);
    chk("d100_rst_done", 32'(if2.initial_done), 32'h0);
    tick;
    tick;
    rst_n2 = 1'b1;
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      tick;
      cnt++;
      if (if2.initial_done) break;
    end
    chk("d100_clear_cycles", 32'(cnt), 32'd100);

    if2.enb = 1'b1; if2.addrb = 7'd3;
    tick;
    chk("d100_rd3", if2.doutb, 32'h5A5A_0F0F);
    if2.addrb = 7'd100;
    tick;
    chk("d100_rd100_d", if2.doutb, 32'h0);
    chk("d100_rd100_v", 32'(if2.doutb_valid), 32'h1);
    if2.enb = 1'b0;
    if2.wea = 4'hF; if2.addra = 7'd110; if2.dina = 32'hFFFF_FFFF;
    tick;
    if2.addra = 7'd99; if2.dina = 32'h1234_5678;
    tick;
    if2.wea = 4'h0;
    for (int j = 0; j < 100; j++) begin
      if2.enb = 1'b1;
      if2.addrb = 7'(j);
      tick;
      chk($sformatf("d100_rd_%0d", j), if2.doutb, (j == 99) ? 32'h1234_5678 : 32'h5A5A_0F0F);
    end
    if2.addrb = 7'd110;
    tick;
    chk("d100_rd110_d", if2.doutb, 32'h0);
    chk("d100_rd110_v", 32'(if2.doutb_valid), 32'h1);
    if2.enb = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sdpram_init_bwe.md
# sdpram_init_bwe

Simple dual-port RAM with one write port and one read port. It adds byte-lane write enables, a selectable 1- or 2-cycle read latency, a read-valid strobe, and a hardware clear-to-constant sequence that runs after reset and again on request. It sits between datapath producers and consumers wherever a table or buffer must start from a known value and be re-clearable without a reset. It is the parametrised successor to the single-width, clear-on-reset SDP RAM.

## Interface

Parameters:
- RAM_WIDTH, 32, data width in bits; must be a multiple of BYTE_WIDTH.
- RAM_DEPTH, 128, number of words; need not be a power of two.
- BYTE_WIDTH, 8, bits per write-enable lane. NB = RAM_WIDTH/BYTE_WIDTH.
- READ_LATENCY, 1, either 1 or 2. Any other value is an elaboration error.
- INIT_VALUE, 0, RAM_WIDTH-bit word written to every location by the clear sequence.
- INIT_ON_RESET, 1. When 1, the clear sequence runs after reset release. When 0, the block is ready immediately.

Ports (AW = $clog2(RAM_DEPTH)):
- clk, in, 1, the single clock; all logic on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- init_req, in, 1, one-cycle request to re-run the clear sequence.
- dina, in, RAM_WIDTH, write data.
- addra, in, AW, write address.
- wea, in, NB, per-lane write enable; lane i covers dina[i*BYTE_WIDTH +: BYTE_WIDTH].
- enb, in, 1, read enable.
- addrb, in, AW, read address.
- doutb, out, RAM_WIDTH, read data.
- doutb_valid, out, 1, doutb carries the result of an accepted read.
- initial_done, out, 1, clear sequence complete; user ports live.

## Operation

- State machine with two states, INIT and READY.
  - Reset state is INIT if INIT_ON_RESET=1, else READY.
  - Clear counter clr_addr (AW bits) resets to 0.
- INIT behaviour:
  - Each cycle writes INIT_VALUE, all lanes enabled, to clr_addr, then increments clr_addr.
  - After the edge that writes RAM_DEPTH-1, go to READY and clear clr_addr to 0.
  - User writes (wea) are dropped.
  - enb is ignored and doutb_valid stays 0.
  - init_req is ignored.
- READY behaviour:
  - Write: on an edge with wea[i]=1 and addra<RAM_DEPTH, lane i of mem[addra] takes lane i of dina. Other lanes are unchanged.
  - Read: on an edge with enb=1, the read is accepted.
  - init_req=1 at an edge moves the state to INIT with clr_addr=0.
- Read data source:
  - If addrb<RAM_DEPTH, doutb returns mem[addrb].
  - If addrb>=RAM_DEPTH, doutb returns all-zero with doutb_valid still asserted.
  - Out-of-range writes are dropped.
- Read-during-write to the same address returns the old data (read-first).
- doutb holds its last value when no read completes. Only doutb_valid pulses.
- initial_done = (state==READY), registered.
  - Reset value is 0 if INIT_ON_RESET=1, else 1.
- Memory contents are not reset. Only the clear sequence defines them.
- Reset values: doutb=0, doutb_valid=0, initial_done as above, all pipeline registers 0.

## Timing

- Reset-triggered clear:
  - Let E1 be the first rising edge after rst_n deasserts.
  - Edges E1..E_RAM_DEPTH write addresses 0..RAM_DEPTH-1.
  - initial_done is 1 after edge E_RAM_DEPTH: the clear lasts exactly RAM_DEPTH cycles.
- init_req sampled in READY at edge R:
  - initial_done falls after R.
  - Clear writes occur at R+1..R+RAM_DEPTH.
  - initial_done rises after R+RAM_DEPTH.
  - A user write presented at edge R is still performed, then overwritten by the clear.
- Read latency:
  - READ_LATENCY=1: a read accepted at edge N gives doutb and doutb_valid=1 after N+1.
  - READ_LATENCY=2: the same read gives them after N+2, via an output register stage.
  - Back-to-back reads give one result per cycle.
- Reads accepted in READY just before init_req complete normally through the pipeline.
- Reset mid-operation:
  - rst_n low at any time immediately clears outputs and pipeline, and sets state per INIT_ON_RESET.
  - A partially finished clear restarts from address 0 after release.
- Write and read: a write at edge N is visible to a read accepted at edge N+1 or later.

## Test plan

- Power-on clear (WIDTH=32, DEPTH=128, INIT_VALUE=32'hA5A5_A5A5, LAT=1):
  - Release reset, then keep enb=1 with wea=F on all addresses during the clear.
  - initial_done rises exactly 128 cycles after E1, with no doutb_valid before that.
  - Reads of 0..127 then return A5A5_A5A5, so the dropped writes had no effect.
- Byte lanes: after the clear, write 32'h1122_3344 to address 5 with wea=4'b0101.
  - A read of address 5 returns 32'hA522_A544.
- Latency 2: set READ_LATENCY=2 and write the values addr+1 to all addresses.
  - Issue 10 back-to-back reads of 0..9.
  - doutb_valid is high for 10 consecutive cycles starting 2 cycles after the first read, and the data is 1..10.
- Read-first collision: mem[7]=32'h0000_0001. In the same cycle, write 32'h0000_0002 to address 7 and read address 7.
  - The read returns 1; the next read returns 2.
- Re-init: in READY, pulse init_req.
  - initial_done is low for exactly 128 cycles.
  - All addresses afterwards read INIT_VALUE.
  - An init_req pulsed mid-clear does not extend the low time.
- Reset mid-clear and non-power-of-two depth: set DEPTH=100 and assert rst_n low at clear cycle 40.
  - Outputs go to 0 immediately.
  - After release, the clear takes 100 cycles.
  - A read of address 100 returns 0 with doutb_valid=1.
  - A write to address 110 corrupts nothing.
